// File: rtl/top_level.sv
// Fixed-function processor: 256x8 data memory plus three built-in programs run in rotation
// (Hamming encode, Hamming decode/correct, 5-bit pattern count), one program per START.
module top_level (
  input  logic CLK,
  input  logic RESET,
  input  logic START,
  output logic DONE
);

  typedef enum logic [2:0] {StIdle, StRun1, StRun2, StRun3, StFin} state_e;

  state_e      state_q, state_d;
  logic [1:0]  prog_q, prog_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  cnt_win_q, cnt_win_d;
  logic [7:0]  cnt_byte_q, cnt_byte_d;
  logic [7:0]  cnt_bit_q, cnt_bit_d;

  logic        pair_we, cnt_we;
  logic [7:0]  rd_addr0, rd_addr1, pair_addr;
  logic [7:0]  rd_lo, rd_hi;
  logic [4:0]  rd_pat;
  logic [15:0] pair_data;

  // Encoder
  logic [11:1] d_enc;
  logic        p8, p4, p2, p1, p0;
  logic [15:0] enc_w;

  // Decoder
  logic [15:0] r;
  logic [3:0]  syn;
  logic        par;
  logic [1:0]  flag;
  logic [10:0] dec_data;
  logic [15:0] dec_o;

  // Pattern counter
  logic [11:0] win;
  logic [2:0]  n_in;
  logic [3:0]  n_bit;

  // Address generation: P1/P2 walk 16-bit pairs, P3 walks bytes with one byte of lookahead.
  always_comb begin
    if (state_q == StRun3) begin
      rd_addr0 = 8'd128 + {3'b000, idx_q};
    end else if (state_q == StRun2) begin
      rd_addr0 = 8'd64 + {2'b00, idx_q, 1'b0};
    end else begin
      rd_addr0 = {2'b00, idx_q, 1'b0};
    end
    rd_addr1  = rd_addr0 + 8'd1;
    pair_addr = ((state_q == StRun2) ? 8'd94 : 8'd30) + {2'b00, idx_q, 1'b0};
  end

  always_comb begin
    d_enc = {rd_hi[2:0], rd_lo};
    p8    = ^d_enc[11:5];
    p4    = ^{d_enc[11:8], d_enc[4:2]};
    p2    = ^{d_enc[11], d_enc[10], d_enc[7], d_enc[6], d_enc[4], d_enc[3], d_enc[1]};
    p1    = ^{d_enc[11], d_enc[9], d_enc[7], d_enc[5], d_enc[4], d_enc[2], d_enc[1]};
    p0    = ^{d_enc, p8, p4, p2, p1};
    enc_w = {d_enc[11:5], p8, d_enc[4:2], p4, d_enc[1], p2, p1, p0};
  end

  always_comb begin
    int dpos;
    r   = {rd_hi, rd_lo};
    syn = '0;
    for (int k = 1; k < 16; k++) begin
      if (r[k]) syn = syn ^ 4'(k);
    end
    par      = ^r;
    dpos     = 0;
    dec_data = '0;
    // Data bits sit at the non-power-of-two positions; only a single error (par=1) is corrected.
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        dec_data[dpos] = r[k] ^ (par && (syn == 4'(k)));
        dpos = dpos + 1;
      end
    end
    if (par)               flag = 2'b01;
    else if (syn != 4'd0)  flag = 2'b10;
    else                   flag = 2'b00;
    dec_o = {flag, 3'b000, dec_data};
  end

  always_comb begin
    win   = {rd_lo, rd_hi[7:4]};
    n_in  = '0;
    n_bit = '0;
    // Offsets 0..3 are the in-byte windows; 4..7 reach into the next byte, absent for byte 31.
    for (int j = 0; j < 8; j++) begin
      if (win[11-j -: 5] == rd_pat) begin
        if (j < 4) n_in = n_in + 3'd1;
        if (j < 4 || idx_q != 5'd31) n_bit = n_bit + 4'd1;
      end
    end
  end

  assign pair_data = (state_q == StRun2) ? dec_o : enc_w;
  assign DONE      = (state_q == StFin);

  always_comb begin
    state_d    = state_q;
    prog_d     = prog_q;
    idx_d      = idx_q;
    cnt_win_d  = cnt_win_q;
    cnt_byte_d = cnt_byte_q;
    cnt_bit_d  = cnt_bit_q;
    pair_we    = 1'b0;
    cnt_we     = 1'b0;
    unique case (state_q)
      StIdle, StFin: begin
        if (START) begin
          idx_d = '0;
          unique case (prog_q)
            2'd0:    state_d = StRun1;
            2'd1:    state_d = StRun2;
            default: begin
              state_d    = StRun3;
              cnt_win_d  = '0;
              cnt_byte_d = '0;
              cnt_bit_d  = '0;
            end
          endcase
          prog_d = (prog_q == 2'd2) ? 2'd0 : prog_q + 2'd1;
        end
      end
      StRun1, StRun2: begin
        pair_we = 1'b1;
        idx_d   = idx_q + 5'd1;
        if (idx_q == 5'd14) state_d = StFin;
      end
      StRun3: begin
        cnt_we     = 1'b1;
        idx_d      = idx_q + 5'd1;
        cnt_win_d  = cnt_win_q + {5'b00000, n_in};
        cnt_byte_d = cnt_byte_q + {7'b0000000, (n_in != 3'd0)};
        cnt_bit_d  = cnt_bit_q + {4'b0000, n_bit};
        if (idx_q == 5'd31) state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIdle;
      prog_q     <= 2'd0;
      idx_q      <= '0;
      cnt_win_q  <= '0;
      cnt_byte_q <= '0;
      cnt_bit_q  <= '0;
    end else begin
      state_q    <= state_d;
      prog_q     <= prog_d;
      idx_q      <= idx_d;
      cnt_win_q  <= cnt_win_d;
      cnt_byte_q <= cnt_byte_d;
      cnt_bit_q  <= cnt_bit_d;
    end
  end

  if (1) begin : dp
    if (1) begin : dm
      logic [7:0] core [0:255];

      assign rd_lo  = core[rd_addr0];
      assign rd_hi  = core[rd_addr1];
      assign rd_pat = core[160][4:0];

      // Not reset; a RESET cycle suppresses writes so partial results stay as they were.
      always_ff @(posedge CLK) begin
        if (!RESET && pair_we) begin
          core[pair_addr]              <= pair_data[7:0];
          core[{pair_addr[7:1], 1'b1}] <= pair_data[15:8];
        end
        if (!RESET && cnt_we) begin
          core[192] <= cnt_win_d;
          core[193] <= cnt_byte_d;
          core[194] <= cnt_bit_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: program rotation, handshake, reset mid-run and memory results.
module tb_top_level;

  logic CLK;
  logic RESET;
  logic START;
  logic DONE;

  int checks = 0;
  int errors = 0;

  top_level dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input int a, input logic [7:0] exp);
    check(tag, dut.dp.dm.core[a], exp);
  endtask

  task automatic mem_wr(input int a, input logic [7:0] v);
    dut.dp.dm.core[a] <= v;
  endtask

  // Pulse START, check DONE drops, then wait (bounded) for DONE; optionally poke START mid-run.
  task automatic run_prog(input string tag, input bit poke);
    int n;
    START = 1'b1;
    tick();
    START = 1'b0;
    check({tag, "_done_low"}, {7'b0, DONE}, 8'h00);
    n = 1;
    while (DONE !== 1'b1 && n < 64) begin
      START = (poke && n == 3);
      tick();
      n++;
    end
    START = 1'b0;
    check({tag, "_done_within_64"}, {7'b0, DONE}, 8'h01);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    tick();
    tick();
    check("done_in_reset", {7'b0, DONE}, 8'h00);
    RESET = 1'b0;
    tick();
    check("done_idle", {7'b0, DONE}, 8'h00);

    for (int i = 0; i < 30; i++) mem_wr(i, 8'h00);
    for (int i = 30; i < 60; i++) mem_wr(i, 8'hAA);
    mem_wr(0, 8'h01); mem_wr(1, 8'h00);
    mem_wr(2, 8'hFF); mem_wr(3, 8'h07);
    mem_wr(6, 8'h02); mem_wr(7, 8'h00);
    for (int i = 64; i < 94; i++) mem_wr(i, 8'h00);
    mem_wr(64, 8'h07); mem_wr(65, 8'h00);
    mem_wr(66, 8'h0E); mem_wr(67, 8'h00);
    mem_wr(68, 8'hFF); mem_wr(69, 8'hFF);
    mem_wr(70, 8'h27); mem_wr(71, 8'h00);
    mem_wr(72, 8'h33); mem_wr(73, 8'h00);
    for (int i = 128; i < 161; i++) mem_wr(i, 8'h00);
    mem_wr(192, 8'h11); mem_wr(193, 8'h11); mem_wr(194, 8'h11);
    tick();

    // P1 encode, with a START pulse mid-run that must be ignored
    run_prog("p1", 1'b1);
    chk_mem("p1_d001_lo", 30, 8'h0F);
    chk_mem("p1_d001_hi", 31, 8'h00);
    chk_mem("p1_d7ff_lo", 32, 8'hFF);
    chk_mem("p1_d7ff_hi", 33, 8'hFF);
    chk_mem("p1_d000_lo", 34, 8'h00);
    chk_mem("p1_d000_hi", 35, 8'h00);
    chk_mem("p1_d002_lo", 36, 8'h33);
    chk_mem("p1_d002_hi", 37, 8'h00);
    tick();
    tick();
    check("done_held", {7'b0, DONE}, 8'h01);

    // P2 decode/correct
    run_prog("p2", 1'b0);
    chk_mem("p2_single_bit3_lo", 94, 8'h01);
    chk_mem("p2_single_bit3_hi", 95, 8'h40);
    chk_mem("p2_single_p0_lo", 96, 8'h01);
    chk_mem("p2_single_p0_hi", 97, 8'h40);
    chk_mem("p2_none_ffff_lo", 98, 8'hFF);
    chk_mem("p2_none_ffff_hi", 99, 8'h07);
    chk_mem("p2_double_lo", 100, 8'h02);
    chk_mem("p2_double_hi", 101, 8'h80);
    chk_mem("p2_clean_lo", 102, 8'h02);
    chk_mem("p2_clean_hi", 103, 8'h00);

    // P3, pattern 0 over an all-zero string
    run_prog("p3_zero", 1'b0);
    chk_mem("p3_zero_windows", 192, 8'h80);
    chk_mem("p3_zero_bytes", 193, 8'h20);
    chk_mem("p3_zero_bits", 194, 8'hFC);

    // Rotation wraps back to P1
    mem_wr(0, 8'h02);
    mem_wr(1, 8'h00);
    mem_wr(30, 8'hAA);
    tick();
    run_prog("p1_wrap", 1'b0);
    chk_mem("p1_wrap_lo", 30, 8'h33);
    chk_mem("p1_wrap_hi", 31, 8'h00);
    chk_mem("p1_wrap_p3_untouched", 192, 8'h80);

    // RESET in the middle of P2
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("done_after_midrun_reset", {7'b0, DONE}, 8'h00);
    tick();
    check("done_stays_low", {7'b0, DONE}, 8'h00);
    mem_wr(0, 8'h01);
    mem_wr(30, 8'hAA);
    tick();
    run_prog("p1_after_reset", 1'b0);
    chk_mem("p1_after_reset_lo", 30, 8'h0F);
    chk_mem("p1_after_reset_hi", 31, 8'h00);

    // P2 then P3 with pattern 10101 (upper pattern bits ignored) over 0x55 bytes
    for (int i = 128; i < 160; i++) mem_wr(i, 8'h55);
    mem_wr(160, 8'hF5);
    tick();
    run_prog("p2_again", 1'b0);
    chk_mem("p2_again_lo", 94, 8'h01);
    run_prog("p3_alt", 1'b0);
    chk_mem("p3_alt_windows", 192, 8'h40);
    chk_mem("p3_alt_bytes", 193, 8'h20);
    chk_mem("p3_alt_bits", 194, 8'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
